// File: rtl/siphash_pkg.sv
// Shared SipHash definitions: packer state encoding, word geometry and IV constants.
package siphash_pkg;

  localparam int unsigned SIPHASH_WORD_W       = 64;
  localparam int unsigned SIPHASH_LEN_BYTE_LSB = 56;

  localparam logic [SIPHASH_WORD_W-1:0] SIPHASH_IV0 = 64'h736f_6d65_7073_6575;
  localparam logic [SIPHASH_WORD_W-1:0] SIPHASH_IV1 = 64'h646f_7261_6e64_6f6d;
  localparam logic [SIPHASH_WORD_W-1:0] SIPHASH_IV2 = 64'h6c79_6765_6e65_7261;
  localparam logic [SIPHASH_WORD_W-1:0] SIPHASH_IV3 = 64'h7465_6462_7974_6573;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    EMIT  = 2'd2
  } packer_state_e;

endpackage

// File: rtl/siphash_msg_packer.sv
// Packs a byte stream into 64-bit little-endian SipHash message words and
// appends the length-tagged final block.
module siphash_msg_packer
  import siphash_pkg::*;
#(
  parameter int unsigned LEN_W = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [7:0]                in_data,
  input  logic                      in_last,
  input  logic                      in_empty,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [SIPHASH_WORD_W-1:0] out_word,
  output logic                      out_final,
  output logic                      busy,
  output logic [LEN_W-1:0]          msg_len
);

  packer_state_e             state_q, state_d;
  logic [2:0]                k_q, k_d;
  logic [SIPHASH_WORD_W-1:0] word_q, word_d;
  logic [LEN_W-1:0]          len_q, len_d;
  logic                      pad_q, pad_d;
  logic                      in_ready_q, in_ready_d;
  logic                      out_valid_q, out_valid_d;
  logic                      out_final_q, out_final_d;
  logic                      busy_q, busy_d;
  logic                      beat_hs, byte_hs, out_hs;

  assign beat_hs = in_valid & in_ready_q;
  assign byte_hs = beat_hs & ~(in_last & in_empty);
  assign out_hs  = out_valid_q & out_ready;

  // Next-state logic; start has priority over every handshake.
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    word_d      = word_q;
    len_d       = len_q;
    pad_d       = pad_q;
    out_final_d = out_final_q;
    busy_d      = busy_q;
    if (start) begin
      state_d     = ACCUM;
      k_d         = 3'd0;
      word_d      = '0;
      len_d       = '0;
      pad_d       = 1'b0;
      out_final_d = 1'b0;
      busy_d      = 1'b1;
    end else begin
      case (state_q)
        ACCUM: begin
          if (byte_hs) begin
            word_d[{k_q, 3'b000} +: 8] = in_data;
            k_d   = k_q + 3'd1;
            len_d = len_q + LEN_W'(1);
          end
          // A full block on the last beat still needs a separate pad block.
          if (beat_hs && in_last) begin
            state_d = EMIT;
            if (byte_hs && k_q == 3'd7) begin
              pad_d       = 1'b1;
              out_final_d = 1'b0;
            end else begin
              word_d[SIPHASH_LEN_BYTE_LSB +: 8] = len_d[7:0];
              out_final_d = 1'b1;
            end
          end else if (byte_hs && k_q == 3'd7) begin
            state_d     = EMIT;
            out_final_d = 1'b0;
          end
        end
        EMIT: begin
          if (out_hs) begin
            if (pad_q) begin
              word_d = '0;
              word_d[SIPHASH_LEN_BYTE_LSB +: 8] = len_q[7:0];
              out_final_d = 1'b1;
              pad_d       = 1'b0;
            end else if (out_final_q) begin
              state_d     = IDLE;
              word_d      = '0;
              out_final_d = 1'b0;
              busy_d      = 1'b0;
            end else begin
              state_d = ACCUM;
              k_d     = 3'd0;
              word_d  = '0;
            end
          end
        end
        default: ;
      endcase
    end
    in_ready_d  = (state_d == ACCUM);
    out_valid_d = (state_d == EMIT);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      k_q         <= 3'd0;
      word_q      <= '0;
      len_q       <= '0;
      pad_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_final_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      word_q      <= word_d;
      len_q       <= len_d;
      pad_q       <= pad_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_final_q <= out_final_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_word  = word_q;
  assign out_final = out_final_q;
  assign busy      = busy_q;
  assign msg_len   = len_q;

endmodule

// File: tb/tb_siphash_msg_packer.sv
// Randomized bench for siphash_msg_packer against a message-level packing model.
module tb_siphash_msg_packer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        in_last;
  logic        in_empty;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_word;
  logic        out_final;
  logic        busy;
  logic [31:0] msg_len;

  int checks   = 0;
  int failures = 0;

  logic [7:0]  cur[$];
  logic [63:0] expq[$];

  always #5 clk = ~clk;

  siphash_msg_packer #(.LEN_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .in_empty(in_empty),
    .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word),
    .out_final(out_final), .busy(busy), .msg_len(msg_len)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Message words: full 8-byte groups little-endian, then tail bytes with length in the top byte.
  function automatic void build_expected();
    int n;
    logic [63:0] w;
    n = cur.size();
    expq.delete();
    for (int b = 0; b < n / 8; b++) begin
      w = '0;
      for (int j = 0; j < 8; j++) w = w | (64'(cur[b*8+j]) << (8*j));
      expq.push_back(w);
    end
    w = '0;
    for (int j = 0; j < n % 8; j++) w = w | (64'(cur[(n/8)*8+j]) << (8*j));
    w = w | (64'(n % 256) << 56);
    expq.push_back(w);
  endfunction

  task automatic fill_seq(input int n);
    cur.delete();
    for (int i = 0; i < n; i++) cur.push_back(8'(i));
  endtask

  task automatic fill_rand(input int n);
    cur.delete();
    for (int i = 0; i < n; i++) cur.push_back(8'($urandom));
  endtask

  task automatic idle_inputs();
    start = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_empty = 1'b0; out_ready = 1'b0;
  endtask

  task automatic run_msg(input bit empty_last, input int stall, input string name);
    int n, nb, bi, acc, cyc, stall_left;
    bit done, exp_ov, prev_stall, bhs, ohs, bl, be;
    logic [63:0] pw;
    logic pf;
    n = cur.size();
    nb = n + (empty_last ? 1 : 0);
    build_expected();
    bi = 0; acc = 0; cyc = 0; stall_left = stall;
    done = 1'b0; exp_ov = 1'b0; prev_stall = 1'b0; pw = '0; pf = 1'b0;
    start = 1'b1; in_valid = 1'b1; in_data = 8'($urandom); in_last = 1'b0; in_empty = 1'b0;
    @(posedge clk); @(negedge clk);
    start = 1'b0; in_valid = 1'b0;
    chk({name, " start busy"}, 64'(busy), 64'd1);
    chk({name, " start msg_len"}, 64'(msg_len), 64'd0);
    chk({name, " start out_valid"}, 64'(out_valid), 64'd0);
    chk({name, " start in_ready"}, 64'(in_ready), 64'd1);
    while (!done && cyc < 4000) begin
      cyc++;
      if (exp_ov) chk({name, " latency"}, 64'(out_valid), 64'd1);
      exp_ov = 1'b0;
      if (out_valid) begin
        chk({name, " exclusive"}, 64'(in_ready), 64'd0);
        if (prev_stall) begin
          chk({name, " hold word"}, out_word, pw);
          chk({name, " hold final"}, 64'(out_final), 64'(pf));
        end
        if (expq.size() > 0) begin
          chk({name, " word"}, out_word, expq[0]);
          chk({name, " final"}, 64'(out_final), 64'(expq.size() == 1));
        end else begin
          chk({name, " extra word"}, 64'(out_valid), 64'd0);
        end
      end
      bl = 1'b0; be = 1'b0;
      if (bi < nb && $urandom_range(3) != 0) begin
        in_valid = 1'b1;
        if (bi < n) begin
          in_data  = cur[bi];
          in_last  = (bi == n - 1) && !empty_last;
          in_empty = in_last ? 1'b0 : 1'($urandom_range(1));
        end else begin
          in_data = 8'($urandom); in_last = 1'b1; in_empty = 1'b1;
        end
        bl = in_last; be = in_empty;
      end else begin
        in_valid = 1'b0; in_data = 8'($urandom);
        in_last = 1'($urandom_range(1)); in_empty = 1'($urandom_range(1));
      end
      if (out_valid && stall_left > 0) begin
        out_ready = 1'b0;
        stall_left--;
      end else begin
        out_ready = ($urandom_range(9) < 7);
      end
      bhs = in_valid && in_ready;
      ohs = out_valid && out_ready;
      prev_stall = out_valid && !out_ready;
      pw = out_word; pf = out_final;
      @(posedge clk);
      if (bhs) begin
        if (!(bl && be)) acc++;
        bi++;
        if (bl || (!(bl && be) && acc % 8 == 0)) exp_ov = 1'b1;
      end
      if (ohs && expq.size() > 0) begin
        if (expq.size() == 1) done = 1'b1;
        void'(expq.pop_front());
      end
      @(negedge clk);
    end
    idle_inputs();
    if (!done) chk({name, " timeout"}, 64'd1, 64'd0);
    chk({name, " end busy"}, 64'(busy), 64'd0);
    chk({name, " end msg_len"}, 64'(msg_len), 64'(n));
    chk({name, " end out_valid"}, 64'(out_valid), 64'd0);
    chk({name, " end in_ready"}, 64'(in_ready), 64'd0);
  endtask

  task automatic start_and_feed(input int cnt);
    start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    repeat (cnt) begin
      in_valid = 1'b1; in_data = 8'($urandom); in_last = 1'b0; in_empty = 1'b0;
      @(posedge clk); @(negedge clk);
    end
    in_valid = 1'b0;
    chk("feed msg_len", 64'(msg_len), 64'(cnt));
  endtask

  task automatic chk_zero(input string name);
    chk({name, " in_ready"}, 64'(in_ready), 64'd0);
    chk({name, " out_valid"}, 64'(out_valid), 64'd0);
    chk({name, " out_word"}, out_word, 64'd0);
    chk({name, " out_final"}, 64'(out_final), 64'd0);
    chk({name, " busy"}, 64'(busy), 64'd0);
    chk({name, " msg_len"}, 64'(msg_len), 64'd0);
  endtask

  initial begin
    int n;
    bit el;
    rst_n = 1'b0; in_data = 8'h00;
    idle_inputs();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;

    in_valid = 1'b1; in_data = 8'hA5;
    repeat (3) begin @(posedge clk); @(negedge clk); end
    in_valid = 1'b0;
    chk_zero("idle ignore");

    cur.delete();  run_msg(1'b1, 0, "empty");
    cur.delete(); cur.push_back(8'h01); cur.push_back(8'h02); cur.push_back(8'h03);
    run_msg(1'b0, 0, "three");
    fill_seq(8);   run_msg(1'b0, 0, "eight");
    fill_seq(15);  run_msg(1'b0, 0, "fifteen");
    fill_rand(10); run_msg(1'b0, 5, "backpressure");
    fill_rand(16); run_msg(1'b1, 2, "sixteen empty-last");
    fill_rand(300); run_msg(1'b0, 0, "long300");

    start_and_feed(5);
    rst_n = 1'b0;
    @(posedge clk); @(negedge clk);
    chk_zero("mid reset");
    rst_n = 1'b1;
    @(posedge clk); @(negedge clk);
    chk_zero("post reset");

    start_and_feed(5);
    fill_rand(11); run_msg(1'b0, 0, "restart");

    for (int m = 0; m < 12; m++) begin
      n = $urandom_range(40);
      el = (n == 0) ? 1'b1 : 1'($urandom_range(1));
      fill_rand(n);
      run_msg(el, $urandom_range(3), "random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/siphash_msg_packer.md
Name: siphash_msg_packer

Overview:
- Upstream feeder for the siphash core.
- Accepts a message as a byte stream on a valid/ready handshake.
- Packs the bytes into 64-bit little-endian message words and appends the SipHash final block: the remaining tail bytes, with (total length mod 256) in the top byte.
- The core's compression stage consumes one word per out_valid/out_ready handshake and uses out_final to start finalisation.

Parameters:
- LEN_W, 32, width of the total-byte counter msg_len; wraps modulo 2^LEN_W.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  pulse; opens a new message. Restarts (aborts) any message in progress.
- in_valid  in  1  in_data / in_last / in_empty are valid.
- in_ready  out  1  packer accepts a byte this cycle.
- in_data  in  8  message byte.
- in_last  in  1  this beat ends the message.
- in_empty  in  1  qualifies in_last only: beat carries no byte, in_data is ignored. Needed for empty messages.
- out_valid  out  1  out_word is valid.
- out_ready  in  1  downstream core consumes out_word.
- out_word  out  64  packed message word m_i.
- out_final  out  1  out_word is the final (length-tagged) block.
- busy  out  1  high from the start cycle until the final-word handshake.
- msg_len  out  LEN_W  bytes accepted so far in the current message.

Behaviour:
- Reset (rst_n=0 at a clock edge), from any state, mid-message included:
  - State goes to IDLE; shift register and counters clear.
  - in_ready=0, out_valid=0, out_word=0, out_final=0, busy=0, msg_len=0.
- States:
  - IDLE: in_ready=0. start → ACCUM; busy=1; byte index k=0; msg_len=0.
  - ACCUM: in_ready=1, out_valid=0. A byte handshake (in_valid & in_ready & !(in_last & in_empty)):
    - writes in_data to bits [8k+7:8k];
    - increments k and msg_len.
  - EMIT: out_valid=1, in_ready=0. out_word and out_final are held stable until out_ready.
- Transitions out of ACCUM:
  - Byte handshake with k→8 and !in_last → EMIT (data word, out_final=0). On the handshake, back to ACCUM with k=0 and word cleared.
  - Handshake with in_last and a partial block → EMIT the final word with out_final=1:
    - partial block means k<8 after the beat, counting 0 new bytes if in_empty;
    - bits [8k-1:0] hold the tail bytes, bits [55:8k] are zero, and bits [63:56] = msg_len[7:0] (0 for an empty message).
    - On its handshake → IDLE, busy=0. msg_len holds its value until the next start.
  - Handshake with in_last and k→8, i.e. the length is a multiple of 8:
    - EMIT the data word (out_final=0);
    - then EMIT a pad word {msg_len[7:0], 56'h0} with out_final=1;
    - then IDLE.
- Latency: out_valid rises on the cycle after the accepting handshake (registered). in_ready and out_valid are never both high.
- start in ACCUM or EMIT: aborts the message. Next cycle is ACCUM, k=0, msg_len=0, out_valid=0, busy=1. start beats in_valid on the same cycle; that byte is not accepted.
- start in IDLE with in_valid high on the same cycle: the byte is not accepted, because in_ready=0 in IDLE.
- in_empty without in_last: ignored as a qualifier, so the beat is a normal byte.
- msg_len wraps modulo 2^LEN_W. The length byte always comes from msg_len[7:0].
- in_valid in IDLE: ignored; no state change.

Decomposition:
- Shared package siphash_pkg:
  - packer state enum (IDLE, ACCUM, EMIT);
  - SIPHASH_WORD_W=64;
  - SIPHASH_LEN_BYTE_LSB=56;
  - the four IV constants, shared with the core.
- No sub-module. A single module is natural, with a shift register, byte counter, length counter and a 3-state FSM.

Test Plan:
1. Empty message: start; one beat with in_last=1, in_empty=1 → one word 64'h0000_0000_0000_0000 with out_final=1; msg_len=0; busy falls after the handshake.
2. Three bytes 01,02,03, last on 03 → single word 64'h0300_0000_0003_0201 with out_final=1; msg_len=3.
3. Eight bytes 00..07, last on 07 → 64'h0706_0504_0302_0100 with final=0, then 64'h0800_0000_0000_0000 with final=1.
4. Fifteen bytes 00..0E → 64'h0706_0504_0302_0100 with final=0, then 64'h0F0E_0D0C_0B0A_0908 with final=1.
5. Backpressure: out_ready=0 for 5 cycles during EMIT → out_word/out_final stable, in_ready=0; word consumed on the first out_ready=1 cycle.
6. Disruption:
   - 300-byte message → final word top byte 8'h2C, msg_len=300.
   - rst_n=0 after byte 5 of a message → all outputs zero, IDLE.
   - start mid-message → msg_len=0 and the next word contains only the new bytes.
